// File: rtl/adder16b_seq_ctrl.sv
// Purpose : 16-bit add/subtract sequenced through one external 4-bit adder, one nibble per cycle.
// Latency : done pulses in the cycle after the 4th edge following the start-sampling edge (5 cycles start..done).
// Backpressure: none; start is ignored while busy or done, so the caller must wait for done before the next start.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, sub, cin     begin an operation; 0 = A+B+cin, 1 = A-B (cin ignored)
//   op_a, op_b          16-bit operands, latched when start is accepted
//   add_a/add_b/add_cin nibble operands and carry to the external adder (0 outside RUN)
//   add_s/add_cout      combinational sum nibble and carry back from the adder
//   busy, done          busy while nibbles are in flight; done is a one-cycle completion pulse
//   sum, cout, ovf      registered result, final carry (no-borrow when sub=1), signed overflow
module adder16b_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sub,
    input  logic        cin,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic [3:0]  add_a,
    output logic [3:0]  add_b,
    output logic        add_cin,
    input  logic [3:0]  add_s,
    input  logic        add_cout,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic        sub_reg;
    logic        carry;
    logic [11:0] acc;
    logic [3:0]  nib_b;

    // Adder drive is decoded from registered state only, so an async reset
    // zeroes it immediately without waiting for an edge.
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        nib_b   = b_reg[{idx, 2'b00} +: 4];
        if (state == S_RUN) begin
            add_a   = a_reg[{idx, 2'b00} +: 4];
            // Subtract is A + ~B + 1; the +1 comes from the preloaded carry.
            add_b   = sub_reg ? ~nib_b : nib_b;
            add_cin = carry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            idx     <= 2'd0;
            a_reg   <= 16'h0000;
            b_reg   <= 16'h0000;
            sub_reg <= 1'b0;
            carry   <= 1'b0;
            acc     <= 12'h000;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= 16'h0000;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b;
                        sub_reg <= sub;
                        carry   <= sub ? 1'b1 : cin;
                        idx     <= 2'd0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    carry <= add_cout;
                    idx   <= idx + 2'd1;
                    case (idx)
                        2'd0: acc[3:0]  <= add_s;
                        2'd1: acc[7:4]  <= add_s;
                        2'd2: acc[11:8] <= add_s;
                        default: begin
                            // Last nibble goes straight into the result; add_b[3]
                            // is the effective (possibly inverted) B sign bit.
                            sum   <= {add_s, acc};
                            cout  <= add_cout;
                            ovf   <= (a_reg[15] == add_b[3]) && (add_s[3] != a_reg[15]);
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    endcase
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder16b_seq_ctrl.sv
// Directed bench for adder16b_seq_ctrl with a behavioural 4-bit adder
// closing the loop between add_* outputs and add_s/add_cout inputs.
module tb_adder16b_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_s;
    logic        add_cout;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // The existing 4-bit adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

    adder16b_seq_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .cin      (cin),
        .op_a     (op_a),
        .op_b     (op_b),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_adder_idle(input string tag);
        check({tag, "_add_a"},   {28'h0, add_a},   32'h0);
        check({tag, "_add_b"},   {28'h0, add_b},   32'h0);
        check({tag, "_add_cin"}, {31'h0, add_cin}, 32'h0);
    endtask

    // Runs one operation starting with start driven now (just after an edge).
    // With hold=1, start stays high and the operand inputs are scrambled
    // during RUN and DONE; the result must still come from the first operands.
    // Returns just after the negedge of the IDLE cycle following DONE.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s, input logic hold,
                          input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        logic [15:0] bb;
        logic        c0;
        logic [16:0] m;
        logic [16:0] t;
        bb = s ? ~b : b;
        c0 = s ? 1'b1 : c;
        op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin
            op_a = 16'hAAAA; op_b = 16'h5555; sub = ~s; cin = ~c;
        end else begin
            start = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m = (17'd1 << (4 * i)) - 17'd1;
            t = ({1'b0, a} & m) + ({1'b0, bb} & m) + {16'h0, c0};
            check($sformatf("%s_busy%0d", tag, i),    {31'h0, busy},    32'h1);
            check($sformatf("%s_done%0d", tag, i),    {31'h0, done},    32'h0);
            check($sformatf("%s_add_a%0d", tag, i),   {28'h0, add_a},   {28'h0, a[4*i +: 4]});
            check($sformatf("%s_add_b%0d", tag, i),   {28'h0, add_b},   {28'h0, bb[4*i +: 4]});
            check($sformatf("%s_add_cin%0d", tag, i), {31'h0, add_cin}, {31'h0, t[4*i]});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check({tag, "_done"}, {31'h0, done}, 32'h1);
        check({tag, "_busy_done"}, {31'h0, busy}, 32'h0);
        check({tag, "_sum"},  {16'h0, sum},  {16'h0, exp_sum});
        check({tag, "_cout"}, {31'h0, cout}, {31'h0, exp_cout});
        check({tag, "_ovf"},  {31'h0, ovf},  {31'h0, exp_ovf});
        check_adder_idle({tag, "_dn"});
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, "_done_after"}, {31'h0, done}, 32'h0);
        check({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
        check({tag, "_sum_hold"},   {16'h0, sum},  {16'h0, exp_sum});
        check_adder_idle({tag, "_id"});
        if (hold) begin
            start = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = 16'h0; op_b = 16'h0;
        #3;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_sum",  {16'h0, sum},  32'h0);
        check("rst_cout", {31'h0, cout}, 32'h0);
        check("rst_ovf",  {31'h0, ovf},  32'h0);
        check_adder_idle("rst");
        #9;
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("add",      16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("posovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("cin1",     16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
        run_op("sub5m7c0", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub5m7c1", 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_op("subovfc1", 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        run_op("subovfc0", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        // Start held through RUN/DONE, then an immediate follow-on operation.
        run_op("hold",     16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
        run_op("b2b",      16'h0F0F, 16'h00F1, 1'b1, 1'b0, 1'b0, 16'h1001, 1'b0, 1'b0);

        // Abort during nibble index 2.
        op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("abort_busy_pre", {31'h0, busy}, 32'h1);
        check("abort_add_a_pre", {28'h0, add_a}, 32'h2);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_sum",  {16'h0, sum},  32'h0);
        check("abort_cout", {31'h0, cout}, 32'h0);
        check("abort_ovf",  {31'h0, ovf},  32'h0);
        check_adder_idle("abort");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("abort_nodone%0d", k), {31'h0, done}, 32'h0);
        end
        run_op("postrst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder16b_seq_ctrl.md
ADDER16B_SEQ_CTRL -- requirements
Module: adder16b_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The port list SHALL be, in this order:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request to begin one 16-bit operation
- sub  input  1  0 = A+B+cin, 1 = A-B
- cin  input  1  carry-in for add mode; ignored when sub=1
- op_a  input  16  operand A
- op_b  input  16  operand B
- add_a  output  4  nibble A driven to the external 4-bit adder
- add_b  output  4  nibble B driven to the external 4-bit adder
- add_cin  output  1  carry driven to the external 4-bit adder
- add_s  input  4  sum nibble returned by the adder (combinational)
- add_cout  input  1  carry returned by the adder (combinational)
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- sum  output  16  registered result
- cout  output  1  registered final carry (no-borrow flag when sub=1)
- ovf  output  1  registered signed two's-complement overflow

Function
REQ-003 The FSM SHALL have three states: IDLE, RUN (2-bit nibble index 0..3), and DONE.
REQ-004 In IDLE, start=1 at a rising edge SHALL:
- latch op_a, op_b, and sub;
- load the working carry with cin (sub=0) or 1 (sub=1);
- set index=0 and enter RUN.
REQ-005 In RUN with index i:
- add_a SHALL equal op_a_reg[4i+3:4i];
- add_b SHALL equal op_b_reg[4i+3:4i] (sub=0) or its bitwise inverse (sub=1);
- add_cin SHALL equal the working carry.
REQ-006 At each RUN edge:
- accumulator nibble i <= add_s;
- working carry <= add_cout;
- index increments.
REQ-007 At the RUN edge with index=3:
- sum <= {add_s, accumulator[11:0]};
- cout <= add_cout;
- ovf <= (a15 == b'15) && (new sum[15] != a15), where b' is the effective (possibly inverted) B;
- FSM enters DONE.
REQ-008 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-009 Latency: done SHALL be high during the cycle that follows the 4th rising edge after the edge that sampled start, for 5 cycles from start to done inclusive.
REQ-010 busy SHALL be 1 exactly while in RUN, and 0 in IDLE and DONE.
REQ-011 start SHALL be ignored in RUN and DONE; latched operands SHALL NOT change mid-operation; the earliest back-to-back start is the cycle after DONE.
REQ-012 add_a, add_b, and add_cin SHALL be 0 outside RUN.
REQ-013 sum, cout, and ovf SHALL change only at the REQ-007 edge and SHALL hold between operations.
REQ-014 Nibble carries SHALL propagate across all four nibbles, so that a full-width ripple (e.g. 0xFFFF+1) is exact.

Reset
REQ-015 reset=1 SHALL asynchronously force:
- state IDLE, index 0;
- busy=0, done=0, sum=0x0000, cout=0, ovf=0;
- add_a=0, add_b=0, add_cin=0;
- all latched and working registers to 0.
REQ-016 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-017 The first start sampled after reset deasserts SHALL operate normally.

Verification
REQ-018 Add: op_a=0x1234, op_b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0; done exactly 4 edges after start sampled; busy high 4 cycles.
REQ-019 Ripple: 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1; 0x0000+0x0000, cin=1 -> sum=0x0001.
REQ-020 Subtract:
- 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0;
- 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1;
- sub=1 with cin=1 or cin=0 -> identical result.
REQ-021 Busy behaviour: start held high with new operands during RUN and DONE -> ignored, result is from the first operands; a start on the cycle after DONE gives a second correct result with no lost cycle.
REQ-022 Adder port check: the bench inserts the existing 4-bit adder between add_* ports and compares each RUN cycle's add_a, add_b, and add_cin against the expected nibble and carry; all three are 0 in IDLE and DONE.
REQ-023 Reset: assert reset during RUN index 2 -> busy, done, sum, cout, ovf, and add_* go to 0 immediately (before the next edge); no done follows; the next operation 0x00FF+0x0001 -> sum=0x0100.
